// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS memory-access stage: EXE capture, load-data wait/buffer, WB and ID forwarding.
// Optional macro MS_SUBWORD_LOAD_EN enables LB/LBU/LH/LHU extraction; default returns the raw word.
module mem_stage #(
  parameter int ES_TO_MS_BUS_WD = 74,
  parameter int MS_TO_WS_BUS_WD = 70,
  parameter int MS_TO_DS_BUS_WD = 39
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata,
  output logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_bus
);

  logic                       ms_valid_q, ms_valid_d;
  logic                       buf_valid_q, buf_valid_d;
  logic [31:0]                buf_data_q, buf_data_d;
  logic [ES_TO_MS_BUS_WD-1:0] bus_q;

  logic [2:0]  ld_type;
  logic        res_from_mem;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] alu_result;
  logic [31:0] pc;
  logic        ms_ready_go;
  logic [31:0] raw_data;
  logic [31:0] load_data;
  logic [31:0] final_result;

  assign ld_type      = bus_q[73:71];
  assign res_from_mem = bus_q[70];
  assign gr_we        = bus_q[69];
  assign dest         = bus_q[68:64];
  assign alu_result   = bus_q[63:32];
  assign pc           = bus_q[31:0];

  // Buffered data wins; otherwise the SRAM word passes straight through in its data_ok cycle.
  assign raw_data = buf_valid_q ? buf_data_q : data_sram_rdata;

`ifdef MS_SUBWORD_LOAD_EN
  function automatic logic [31:0] align_load(input logic [2:0] t, input logic [1:0] off,
                                             input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (t)
      3'd1:    align_load = {{24{b[7]}}, b};
      3'd2:    align_load = {24'h0, b};
      3'd3:    align_load = {{16{h[15]}}, h};
      3'd4:    align_load = {16'h0, h};
      default: align_load = w;
    endcase
  endfunction

  assign load_data = align_load(ld_type, alu_result[1:0], raw_data);
`else
  logic unused_ld_type;
  assign unused_ld_type = ^ld_type;
  assign load_data      = raw_data;
`endif

  assign final_result   = res_from_mem ? load_data : alu_result;
  assign ms_ready_go    = !res_from_mem | data_sram_data_ok | buf_valid_q;
  assign ms_allowin     = !ms_valid_q | (ms_ready_go & ws_allowin);
  assign ms_to_ws_valid = ms_valid_q & ms_ready_go;
  assign ms_to_ws_bus   = {gr_we, dest, final_result, pc};
  assign ms_to_ds_bus   = {39{ms_valid_q}} & {~ms_ready_go, gr_we, dest, final_result};

  always_comb begin
    ms_valid_d  = ms_valid_q;
    buf_valid_d = buf_valid_q;
    buf_data_d  = buf_data_q;
    if (ms_allowin) begin
      ms_valid_d = es_to_ms_valid;
    end
    // Only a waiting load blocked by WB captures its data; stray data_ok pulses fall through.
    if (ms_to_ws_valid && ws_allowin) begin
      buf_valid_d = 1'b0;
    end else if (ms_valid_q && res_from_mem && !buf_valid_q && data_sram_data_ok && !ws_allowin) begin
      buf_valid_d = 1'b1;
      buf_data_d  = data_sram_rdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid_q  <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_data_q  <= 32'h0;
    end else begin
      ms_valid_q  <= ms_valid_d;
      buf_valid_q <= buf_valid_d;
      buf_data_q  <= buf_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (es_to_ms_valid && ms_allowin) begin
      bus_q <= es_to_ms_bus;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage: vector table, corner sequences, random vs reference model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ws_allowin;
  logic        ms_allowin;
  logic        es_to_ms_valid;
  logic [73:0] es_to_ms_bus;
  logic        ms_to_ws_valid;
  logic [69:0] ms_to_ws_bus;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [38:0] ms_to_ds_bus;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .ws_allowin        (ws_allowin),
    .ms_allowin        (ms_allowin),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .ms_to_ds_bus      (ms_to_ds_bus)
  );

  typedef struct {
    logic        ld;
    logic [2:0]  lt;
    logic [31:0] alu;
    logic [4:0]  dest;
    logic        we;
    logic [31:0] rdata;
    logic [31:0] exp_sub;
    logic [31:0] exp_raw;
  } vec_t;

  typedef struct {
    logic        ld;
    logic [2:0]  lt;
    logic        we;
    logic [4:0]  dest;
    logic [31:0] alu;
    logic [31:0] pc;
    logic        has;
    logic [31:0] data;
  } minst_t;

  vec_t   vecs[10];
  minst_t mq[$];

  task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  function automatic logic [73:0] mk_bus(input logic [2:0] lt, input logic ld, input logic we,
                                         input logic [4:0] dest, input logic [31:0] alu,
                                         input logic [31:0] pc);
    return {lt, ld, we, dest, alu, pc};
  endfunction

  // Byte/half extraction by shifting the word right by the byte offset and masking.
  function automatic logic [31:0] ref_load(input logic [2:0] lt, input logic [31:0] addr,
                                           input logic [31:0] w);
`ifdef MS_SUBWORD_LOAD_EN
    int unsigned off, b, h;
    off = addr % 4;
    b   = (w >> (8 * off)) & 32'hFF;
    h   = (w >> (16 * (off / 2))) & 32'hFFFF;
    case (lt)
      3'd1:    return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      3'd2:    return b;
      3'd3:    return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      3'd4:    return h;
      default: return w;
    endcase
`else
    logic [34:0] unused_args;
    unused_args = {lt, addr};
    return (unused_args == 35'h0) ? w : w;
`endif
  endfunction

  logic [31:0] exp_res;
  logic [31:0] rd[4];
  logic        got;
  logic        have;
  logic [31:0] dval;
  logic        e_valid, e_allow;
  logic [69:0] e_ws;
  logic [6:0]  e_ds_hi;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 3'd0, 32'h0000_1234, 5'd5,  1'b1, 32'h0,         32'h0000_1234, 32'h0000_1234};
    vecs[1] = '{1'b0, 3'd1, 32'hFFFF_0003, 5'd31, 1'b0, 32'h0,         32'hFFFF_0003, 32'hFFFF_0003};
    vecs[2] = '{1'b1, 3'd0, 32'h1000_0000, 5'd2,  1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[3] = '{1'b1, 3'd1, 32'h1000_0002, 5'd3,  1'b1, 32'h8081_7F01, 32'hFFFF_FF81, 32'h8081_7F01};
    vecs[4] = '{1'b1, 3'd2, 32'h1000_0002, 5'd4,  1'b1, 32'h8081_7F01, 32'h0000_0081, 32'h8081_7F01};
    vecs[5] = '{1'b1, 3'd3, 32'h1000_0002, 5'd6,  1'b1, 32'h8081_7F01, 32'hFFFF_8081, 32'h8081_7F01};
    vecs[6] = '{1'b1, 3'd4, 32'h1000_0000, 5'd7,  1'b1, 32'h8081_7F01, 32'h0000_7F01, 32'h8081_7F01};
    vecs[7] = '{1'b1, 3'd1, 32'h1000_0001, 5'd8,  1'b1, 32'h8081_7F01, 32'h0000_007F, 32'h8081_7F01};
    vecs[8] = '{1'b1, 3'd3, 32'h1000_0003, 5'd9,  1'b1, 32'h8081_7F01, 32'hFFFF_8081, 32'h8081_7F01};
    vecs[9] = '{1'b1, 3'd5, 32'h1000_0001, 5'd10, 1'b0, 32'h8081_7F01, 32'h8081_7F01, 32'h8081_7F01};

    resetn = 1'b0; ws_allowin = 1'b1; es_to_ms_valid = 1'b0; es_to_ms_bus = '0;
    data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;
    samp();
    chk("reset_valid",  {69'h0, ms_to_ws_valid}, 70'h0);
    chk("reset_allow",  {69'h0, ms_allowin},     70'h1);
    chk("reset_ds",     {31'h0, ms_to_ds_bus},   70'h0);
    tick();
    resetn = 1'b1;

    for (int i = 0; i < 10; i++) begin
`ifdef MS_SUBWORD_LOAD_EN
      exp_res = vecs[i].exp_sub;
`else
      exp_res = vecs[i].exp_raw;
`endif
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = mk_bus(vecs[i].lt, vecs[i].ld, vecs[i].we, vecs[i].dest, vecs[i].alu, 32'h100 + i);
      tick();
      es_to_ms_valid    = 1'b0;
      data_sram_data_ok = vecs[i].ld;
      data_sram_rdata   = vecs[i].rdata;
      samp();
      chk($sformatf("vec%0d_valid", i), {69'h0, ms_to_ws_valid}, 70'h1);
      chk($sformatf("vec%0d_ws", i), ms_to_ws_bus, {vecs[i].we, vecs[i].dest, exp_res, 32'h100 + i});
      chk($sformatf("vec%0d_ds", i), {31'h0, ms_to_ds_bus}, {31'h0, 1'b0, vecs[i].we, vecs[i].dest, exp_res});
      tick();
      data_sram_data_ok = 1'b0;
    end

    // LW whose data arrives three cycles after capture
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_bus(3'd0, 1'b1, 1'b1, 5'd12, 32'h2000_0000, 32'h200);
    tick();
    es_to_ms_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      samp();
      chk($sformatf("wait%0d_lw", k),    {69'h0, ms_to_ds_bus[38]}, 70'h1);
      chk($sformatf("wait%0d_allow", k), {69'h0, ms_allowin},       70'h0);
      chk($sformatf("wait%0d_valid", k), {69'h0, ms_to_ws_valid},   70'h0);
      tick();
    end
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD_BEEF;
    samp();
    chk("wait_done_valid", {69'h0, ms_to_ws_valid}, 70'h1);
    chk("wait_done_ws", ms_to_ws_bus, {1'b1, 5'd12, 32'hDEAD_BEEF, 32'h200});
    chk("wait_done_allow", {69'h0, ms_allowin}, 70'h1);
    tick();
    data_sram_data_ok = 1'b0;

    // LW whose data arrives while WB stalls for four cycles
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_bus(3'd0, 1'b1, 1'b1, 5'd13, 32'h3000_0000, 32'h300);
    tick();
    es_to_ms_valid = 1'b0; ws_allowin = 1'b0;
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD_BEEF;
    samp();
    chk("held_first_valid", {69'h0, ms_to_ws_valid}, 70'h1);
    chk("held_first_allow", {69'h0, ms_allowin},     70'h0);
    tick();
    data_sram_data_ok = 1'b0; data_sram_rdata = 32'h1111_2222;
    for (int k = 0; k < 3; k++) begin
      samp();
      chk($sformatf("held%0d_valid", k), {69'h0, ms_to_ws_valid}, 70'h1);
      chk($sformatf("held%0d_ws", k), ms_to_ws_bus, {1'b1, 5'd13, 32'hDEAD_BEEF, 32'h300});
      chk($sformatf("held%0d_lw", k), {69'h0, ms_to_ds_bus[38]}, 70'h0);
      tick();
    end
    ws_allowin = 1'b1;
    samp();
    chk("held_leave_valid", {69'h0, ms_to_ws_valid}, 70'h1);
    chk("held_leave_allow", {69'h0, ms_allowin},     70'h1);
    tick();
    samp();
    chk("held_gone_valid", {69'h0, ms_to_ws_valid}, 70'h0);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_bus(3'd0, 1'b1, 1'b1, 5'd14, 32'h3000_0004, 32'h304);
    tick();
    es_to_ms_valid = 1'b0;
    samp();
    chk("bufclr_lw",    {69'h0, ms_to_ds_bus[38]}, 70'h1);
    chk("bufclr_valid", {69'h0, ms_to_ws_valid},   70'h0);
    tick();
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0BAD_F00D;
    samp();
    chk("bufclr_ws", ms_to_ws_bus, {1'b1, 5'd14, 32'h0BAD_F00D, 32'h304});
    tick();
    data_sram_data_ok = 1'b0;

    // Back-to-back loads, one data_ok per cycle
    rd[0] = 32'hA0A0_0001; rd[1] = 32'hB1B1_0002; rd[2] = 32'hC2C2_0003; rd[3] = 32'hD3D3_0004;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_bus(3'd0, 1'b1, 1'b1, 5'd16, 32'h4000_0000, 32'h400);
    tick();
    for (int k = 1; k <= 4; k++) begin
      es_to_ms_valid = (k < 4);
      es_to_ms_bus   = mk_bus(3'd0, 1'b1, 1'b1, 5'd16 + 5'(k), 32'h4000_0000 + 32'(4 * k), 32'h400 + 32'(k));
      data_sram_data_ok = 1'b1; data_sram_rdata = rd[k-1];
      samp();
      chk($sformatf("b2b%0d_valid", k), {69'h0, ms_to_ws_valid}, 70'h1);
      chk($sformatf("b2b%0d_ws", k), ms_to_ws_bus, {1'b1, 5'd16 + 5'(k - 1), rd[k-1], 32'h400 + 32'(k - 1)});
      chk($sformatf("b2b%0d_allow", k), {69'h0, ms_allowin}, 70'h1);
      tick();
    end
    data_sram_data_ok = 1'b0; es_to_ms_valid = 1'b0;

    // Reset pulse while a load waits, then a stale data_ok
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_bus(3'd0, 1'b1, 1'b1, 5'd20, 32'h5000_0000, 32'h500);
    tick();
    es_to_ms_valid = 1'b0;
    resetn = 1'b0;
    #1;
    chk("rst_mid_valid", {69'h0, ms_to_ws_valid}, 70'h0);
    chk("rst_mid_allow", {69'h0, ms_allowin},     70'h1);
    chk("rst_mid_ds",    {31'h0, ms_to_ds_bus},   70'h0);
    tick();
    resetn = 1'b1;
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD_BEEF;
    samp();
    chk("rst_stale_valid", {69'h0, ms_to_ws_valid}, 70'h0);
    chk("rst_stale_allow", {69'h0, ms_allowin},     70'h1);
    chk("rst_stale_ds",    {31'h0, ms_to_ds_bus},   70'h0);
    tick();
    data_sram_data_ok = 1'b0;
    samp();
    chk("rst_after_valid", {69'h0, ms_to_ws_valid}, 70'h0);

    // Random traffic against the reference model
    mq.delete();
    for (int c = 0; c < 3000; c++) begin
      tick();
      ws_allowin        = ($urandom_range(0, 9) < 7);
      es_to_ms_valid    = $urandom_range(0, 1);
      data_sram_data_ok = ($urandom_range(0, 9) < 4);
      data_sram_rdata   = $urandom;
      es_to_ms_bus      = mk_bus(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                 5'($urandom_range(0, 31)), $urandom, $urandom);
      samp();
      have    = (mq.size() > 0);
      e_valid = 1'b0;
      e_allow = 1'b1;
      e_ws    = '0;
      e_ds_hi = '0;
      if (have) begin
        got     = !mq[0].ld || mq[0].has || data_sram_data_ok;
        dval    = mq[0].has ? mq[0].data : data_sram_rdata;
        exp_res = mq[0].ld ? ref_load(mq[0].lt, mq[0].alu, dval) : mq[0].alu;
        e_valid = got;
        e_allow = got && ws_allowin;
        e_ws    = {mq[0].we, mq[0].dest, exp_res, mq[0].pc};
        e_ds_hi = {!got, mq[0].we, mq[0].dest};
      end
      chk("rnd_valid", {69'h0, ms_to_ws_valid}, {69'h0, e_valid});
      chk("rnd_allow", {69'h0, ms_allowin},     {69'h0, e_allow});
      chk("rnd_ds_hi", {63'h0, ms_to_ds_bus[38:32]}, {63'h0, e_ds_hi});
      if (e_valid) begin
        chk("rnd_ws",     ms_to_ws_bus, e_ws);
        chk("rnd_ds_res", {38'h0, ms_to_ds_bus[31:0]}, {38'h0, e_ws[63:32]});
      end
      if (!have) begin
        chk("rnd_ds_idle", {31'h0, ms_to_ds_bus}, 70'h0);
      end
      if (have && e_valid && ws_allowin) begin
        void'(mq.pop_front());
      end else if (have && mq[0].ld && !mq[0].has && data_sram_data_ok) begin
        mq[0].has  = 1'b1;
        mq[0].data = data_sram_rdata;
      end
      if (es_to_ms_valid && e_allow) begin
        mq.push_back('{es_to_ms_bus[70], es_to_ms_bus[73:71], es_to_ms_bus[69], es_to_ms_bus[68:64],
                       es_to_ms_bus[63:32], es_to_ms_bus[31:0], 1'b0, 32'h0});
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
